// File: rtl/cardinal_pe_port.sv
// Processor-element port of a Cardinal ring router: one-entry per-VC injection and
// ejection buffers between the NIC and the cw/ccw rings, scheduled by even/odd polarity.
module cardinal_pe_port #(
  parameter int PACKET_SIZE = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   polarity,
  input  logic                   pesi,
  output logic                   peri,
  input  logic [PACKET_SIZE-1:0] pedi,
  output logic                   peso,
  input  logic                   pero,
  output logic [PACKET_SIZE-1:0] pedo,
  output logic                   cwo_valid,
  input  logic                   cwo_ready,
  output logic [PACKET_SIZE-1:0] cwo_data,
  output logic                   ccwo_valid,
  input  logic                   ccwo_ready,
  output logic [PACKET_SIZE-1:0] ccwo_data,
  input  logic                   cwi_valid,
  output logic                   cwi_ready,
  input  logic [PACKET_SIZE-1:0] cwi_data,
  input  logic                   ccwi_valid,
  output logic                   ccwi_ready,
  input  logic [PACKET_SIZE-1:0] ccwi_data,
  output logic                   inj_err
);

  // Header fields are numbered MSB-first: field bit i lives at vector bit PACKET_SIZE-1-i.
  localparam int VC_BIT  = PACKET_SIZE - 1;
  localparam int DIR_BIT = PACKET_SIZE - 2;
  localparam int HOP_MSB = PACKET_SIZE - 9;
  localparam int HOP_LSB = PACKET_SIZE - 16;

  typedef logic [PACKET_SIZE-1:0] pkt_t;

  pkt_t       inj_buf [2];
  pkt_t       ej_buf  [2];
  logic [1:0] inj_full;
  logic [1:0] ej_full;
  logic [1:0] rr;

  logic       ext_vc;
  logic       int_vc;
  logic [7:0] hop_in;
  logic       inj_take;
  logic       inj_drop;
  logic       inj_store;
  logic       inj_drain;
  logic       cw_elig;
  logic       ccw_elig;
  logic       ej_open;
  pkt_t       inj_fwd;

  assign ext_vc = polarity;
  assign int_vc = ~polarity;

  // NIC side: only the external-phase VC talks to the NIC.
  assign hop_in    = pedi[HOP_MSB:HOP_LSB];
  assign peri      = ~inj_full[ext_vc];
  assign inj_take  = pesi & peri;
  assign inj_drop  = inj_take & (hop_in == 8'd0);
  assign inj_store = inj_take & ~inj_drop;

  // NOTE: every always_comb output gets a full default first, so no path can infer a latch.
  always_comb begin
    inj_fwd                  = pedi;
    inj_fwd[HOP_MSB:HOP_LSB] = hop_in - 8'd1;
  end

  // Ring side: the internal-phase VC offers its packet on the direction in its header.
  assign cwo_valid  = inj_full[int_vc] & ~inj_buf[int_vc][DIR_BIT];
  assign ccwo_valid = inj_full[int_vc] &  inj_buf[int_vc][DIR_BIT];
  assign cwo_data   = cwo_valid  ? inj_buf[int_vc] : '0;
  assign ccwo_data  = ccwo_valid ? inj_buf[int_vc] : '0;
  assign inj_drain  = (cwo_valid & cwo_ready) | (ccwo_valid & ccwo_ready);

  assign cw_elig    = cwi_valid  & (cwi_data[VC_BIT]  == int_vc);
  assign ccw_elig   = ccwi_valid & (ccwi_data[VC_BIT] == int_vc);
  assign ej_open    = ~ej_full[int_vc];
  // rr only matters when both directions compete; a lone requester always wins.
  assign cwi_ready  = ej_open & cw_elig  & ~(ccw_elig & rr[int_vc]);
  assign ccwi_ready = ej_open & ccw_elig & ~(cw_elig & ~rr[int_vc]);

  assign peso = ej_full[ext_vc] & pero;
  assign pedo = ej_full[ext_vc] ? ej_buf[ext_vc] : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      polarity <= 1'b0;
      inj_full <= '0;
      ej_full  <= '0;
      rr       <= '0;
      inj_err  <= 1'b0;
    end else begin
      polarity <= ~polarity;
      if (inj_store)               inj_full[ext_vc] <= 1'b1;
      if (inj_drain)               inj_full[int_vc] <= 1'b0;
      if (inj_drop)                inj_err          <= 1'b1;
      if (cwi_ready | ccwi_ready)  ej_full[int_vc]  <= 1'b1;
      if (ej_open & cw_elig & ccw_elig) rr[int_vc]  <= ~rr[int_vc];
      if (peso)                    ej_full[ext_vc]  <= 1'b0;
    end
  end

  // NOTE: packet storage is intentionally not reset; the full flags qualify every read.
  always_ff @(posedge clk) begin
    if (inj_store) inj_buf[ext_vc] <= inj_fwd;
    if (cwi_ready)       ej_buf[int_vc] <= cwi_data;
    else if (ccwi_ready) ej_buf[int_vc] <= ccwi_data;
  end

endmodule

// File: tb/tb_cardinal_pe_port.sv
// Self-checking bench for cardinal_pe_port: directed scenarios with literal expectations
// plus a randomized run checked by a behavioural model and per-VC/per-direction scoreboards.
module tb_cardinal_pe_port;
  localparam int PS = 64;

  logic          clk;
  logic          reset;
  logic          polarity;
  logic          pesi, peri, peso, pero;
  logic [PS-1:0] pedi, pedo;
  logic          cwo_valid, cwo_ready, ccwo_valid, ccwo_ready;
  logic [PS-1:0] cwo_data, ccwo_data;
  logic          cwi_valid, cwi_ready, ccwi_valid, ccwi_ready;
  logic [PS-1:0] cwi_data, ccwi_data;
  logic          inj_err;

  int errors = 0;
  int checks = 0;

  cardinal_pe_port #(.PACKET_SIZE(PS)) dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .pesi(pesi), .peri(peri), .pedi(pedi),
    .peso(peso), .pero(pero), .pedo(pedo),
    .cwo_valid(cwo_valid), .cwo_ready(cwo_ready), .cwo_data(cwo_data),
    .ccwo_valid(ccwo_valid), .ccwo_ready(ccwo_ready), .ccwo_data(ccwo_data),
    .cwi_valid(cwi_valid), .cwi_ready(cwi_ready), .cwi_data(cwi_data),
    .ccwi_valid(ccwi_valid), .ccwi_ready(ccwi_ready), .ccwi_data(ccwi_data),
    .inj_err(inj_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk(input logic vc, input logic dir, input logic [7:0] hop,
                                     input logic [15:0] src, input logic [31:0] pay);
    return {vc, dir, 6'd0, hop, src, pay};
  endfunction

  // Behavioural model: per-VC slots holding the packet exactly as the NIC/ring handed it over.
  bit          m_pol, m_err;
  bit          m_inj_full [2];
  bit          m_ej_full  [2];
  bit          m_rr       [2];
  logic [63:0] m_inj_pkt  [2];
  logic [63:0] m_ej_pkt   [2];

  bit          ext, inn;
  bit          x_peri, x_peso, x_cwo_v, x_ccwo_v, x_cwi_r, x_ccwi_r, x_cw_ok, x_ccw_ok;
  logic [63:0] x_pedo, x_cwo_d, x_ccwo_d, fwd;

  task automatic model_reset();
    m_pol = 0; m_err = 0;
    for (int v = 0; v < 2; v++) begin
      m_inj_full[v] = 0; m_ej_full[v] = 0; m_rr[v] = 0;
      m_inj_pkt[v] = '0; m_ej_pkt[v] = '0;
    end
  endtask

  task automatic idle();
    pesi = 0; pedi = '0; pero = 0; cwo_ready = 0; ccwo_ready = 0;
    cwi_valid = 0; cwi_data = '0; ccwi_valid = 0; ccwi_data = '0;
  endtask

  // Compute what this cycle's outputs must be and compare every one of them.
  task automatic eval_cycle();
    #1;
    ext = m_pol;
    inn = !m_pol;
    x_peri   = !m_inj_full[ext];
    x_cwo_v  = m_inj_full[inn] && (m_inj_pkt[inn][62] == 1'b0);
    x_ccwo_v = m_inj_full[inn] && (m_inj_pkt[inn][62] == 1'b1);
    fwd = m_inj_pkt[inn];
    fwd[55:48] = fwd[55:48] - 8'd1;
    x_cwo_d  = x_cwo_v  ? fwd : 64'd0;
    x_ccwo_d = x_ccwo_v ? fwd : 64'd0;
    x_cw_ok  = cwi_valid  && (cwi_data[63]  == inn);
    x_ccw_ok = ccwi_valid && (ccwi_data[63] == inn);
    x_cwi_r = 0;
    x_ccwi_r = 0;
    if (!m_ej_full[inn]) begin
      if (x_cw_ok && x_ccw_ok) begin
        if (m_rr[inn]) x_ccwi_r = 1;
        else           x_cwi_r  = 1;
      end else begin
        x_cwi_r  = x_cw_ok;
        x_ccwi_r = x_ccw_ok;
      end
    end
    x_peso = m_ej_full[ext] && pero;
    x_pedo = m_ej_full[ext] ? m_ej_pkt[ext] : 64'd0;

    check1("polarity", polarity, m_pol);
    check1("peri", peri, x_peri);
    check1("peso", peso, x_peso);
    check("pedo", pedo, x_pedo);
    check1("cwo_valid", cwo_valid, x_cwo_v);
    check("cwo_data", cwo_data, x_cwo_d);
    check1("ccwo_valid", ccwo_valid, x_ccwo_v);
    check("ccwo_data", ccwo_data, x_ccwo_d);
    check1("cwi_ready", cwi_ready, x_cwi_r);
    check1("ccwi_ready", ccwi_ready, x_ccwi_r);
    check1("inj_err", inj_err, m_err);
  endtask

  // Apply this cycle's transfers to the model, then move to the next cycle.
  task automatic advance();
    if (pesi && x_peri) begin
      if (pedi[55:48] == 8'd0) m_err = 1;
      else begin
        m_inj_full[ext] = 1;
        m_inj_pkt[ext]  = pedi;
      end
    end
    if ((x_cwo_v && cwo_ready) || (x_ccwo_v && ccwo_ready)) m_inj_full[inn] = 0;
    if (x_cwi_r)  begin m_ej_full[inn] = 1; m_ej_pkt[inn] = cwi_data;  end
    if (x_ccwi_r) begin m_ej_full[inn] = 1; m_ej_pkt[inn] = ccwi_data; end
    if ((x_cwi_r || x_ccwi_r) && x_cw_ok && x_ccw_ok) m_rr[inn] = !m_rr[inn];
    if (x_peso) m_ej_full[ext] = 0;
    m_pol = !m_pol;
    @(negedge clk);
  endtask

  task automatic sync_pol(input bit p);
    if (m_pol != p) begin
      idle();
      eval_cycle();
      advance();
    end
  endtask

  logic [63:0] nic_q   [2][$];
  logic [63:0] src_q   [2][$];
  logic [63:0] inj_exp [4][$];
  logic [63:0] ej_exp  [4][$];
  int          sent_inj, got_inj, sent_ej, got_ej, idx;
  bit          done, d, vc;
  logic [7:0]  h;
  logic [63:0] p, tmp;

  function automatic bit all_empty();
    bit e;
    e = 1;
    for (int i = 0; i < 2; i++) if (nic_q[i].size() != 0 || src_q[i].size() != 0) e = 0;
    for (int i = 0; i < 4; i++) if (inj_exp[i].size() != 0 || ej_exp[i].size() != 0) e = 0;
    return e;
  endfunction

  initial begin
    idle();
    reset = 1;
    model_reset();
    @(negedge clk);
    #1;
    check1("rst_polarity", polarity, 1'b0);
    check1("rst_peri", peri, 1'b1);
    check1("rst_peso", peso, 1'b0);
    check("rst_pedo", pedo, 64'd0);
    check1("rst_cwo_valid", cwo_valid, 1'b0);
    check1("rst_ccwo_valid", ccwo_valid, 1'b0);
    check("rst_cwo_data", cwo_data, 64'd0);
    check1("rst_inj_err", inj_err, 1'b0);
    @(negedge clk);
    reset = 0;

    // Basic injection: VC0, cw, hop 3, payload 0x11 at p = 0.
    idle();
    pesi = 1; pedi = mk(0, 0, 8'd3, 16'h0001, 32'h11);
    eval_cycle();
    check1("t1_peri", peri, 1'b1);
    advance();
    idle();
    cwo_ready = 1;
    eval_cycle();
    check1("t1_cwo_valid", cwo_valid, 1'b1);
    check("t1_hop", 64'(cwo_data[55:48]), 64'd2);
    check("t1_payload", 64'(cwo_data[31:0]), 64'h11);
    advance();
    idle();
    eval_cycle();
    check1("t1_peri_drained", peri, 1'b1);
    advance();

    // Round-robin ejection on VC1: expect A, then B, then C.
    sync_pol(0);
    idle();
    pero = 1;
    cwi_valid = 1;  cwi_data  = mk(1, 0, 0, 16'h0, 32'hA);
    ccwi_valid = 1; ccwi_data = mk(1, 1, 0, 16'h0, 32'hB);
    eval_cycle();
    check1("rr_grant_cw", cwi_ready, 1'b1);
    check1("rr_hold_ccw", ccwi_ready, 1'b0);
    advance();
    cwi_data = mk(1, 0, 0, 16'h0, 32'hC);
    eval_cycle();
    check1("rr_peso_a", peso, 1'b1);
    check("rr_pedo_a", 64'(pedo[31:0]), 64'hA);
    advance();
    eval_cycle();
    check1("rr_grant_ccw", ccwi_ready, 1'b1);
    check1("rr_hold_cw", cwi_ready, 1'b0);
    advance();
    ccwi_valid = 0; ccwi_data = '0;
    eval_cycle();
    check("rr_pedo_b", 64'(pedo[31:0]), 64'hB);
    advance();
    eval_cycle();
    check1("rr_grant_c", cwi_ready, 1'b1);
    advance();
    cwi_valid = 0; cwi_data = '0;
    eval_cycle();
    check("rr_pedo_c", 64'(pedo[31:0]), 64'hC);
    advance();

    // Backpressure: cw packet on VC0 held off for 6 cycles.
    sync_pol(0);
    idle();
    pesi = 1; pedi = mk(0, 0, 8'd4, 16'h0002, 32'h33);
    eval_cycle();
    advance();
    for (int c = 0; c < 6; c++) begin
      idle();
      eval_cycle();
      if (m_pol) check1("bp_offered", cwo_valid, 1'b1);
      else begin
        check1("bp_not_offered", cwo_valid, 1'b0);
        check1("bp_peri_low", peri, 1'b0);
      end
      advance();
    end
    idle();
    cwo_ready = 1;
    eval_cycle();
    check1("bp_valid", cwo_valid, 1'b1);
    check("bp_payload", 64'(cwo_data[31:0]), 64'h33);
    check("bp_hop", 64'(cwo_data[55:48]), 64'd3);
    advance();
    idle();
    eval_cycle();
    check1("bp_peri_back", peri, 1'b1);
    advance();

    // Hop-0 injection is dropped and flagged stickily.
    sync_pol(1);
    idle();
    pesi = 1; pedi = mk(1, 0, 8'd0, 16'h0003, 32'h44);
    eval_cycle();
    advance();
    idle();
    eval_cycle();
    check1("h0_err", inj_err, 1'b1);
    check1("h0_no_cw", cwo_valid, 1'b0);
    check1("h0_no_ccw", ccwo_valid, 1'b0);
    advance();
    for (int c = 0; c < 3; c++) begin
      idle();
      eval_cycle();
      advance();
    end
    check1("h0_err_sticky", inj_err, 1'b1);

    // Fill all four buffers, then reset mid-cycle.
    sync_pol(0);
    idle();
    pesi = 1; pedi = mk(0, 0, 8'd5, 16'h0, 32'h50);
    cwi_valid = 1; cwi_data = mk(1, 0, 0, 16'h0, 32'h51);
    eval_cycle();
    check1("fill_ej1", cwi_ready, 1'b1);
    advance();
    idle();
    pesi = 1; pedi = mk(1, 1, 8'd5, 16'h0, 32'h52);
    cwi_valid = 1; cwi_data = mk(0, 1, 0, 16'h0, 32'h53);
    eval_cycle();
    check1("fill_cw_wait", cwo_valid, 1'b1);
    advance();
    idle();
    eval_cycle();
    check1("fill_ccw_wait", ccwo_valid, 1'b1);
    check1("fill_peri_low", peri, 1'b0);
    pero = 1;
    #1;
    reset = 1;
    #1;
    check1("mid_rst_cwo", cwo_valid, 1'b0);
    check1("mid_rst_ccwo", ccwo_valid, 1'b0);
    check1("mid_rst_peso", peso, 1'b0);
    check("mid_rst_pedo", pedo, 64'd0);
    check1("mid_rst_peri", peri, 1'b1);
    check1("mid_rst_err", inj_err, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 0;
    for (int c = 0; c < 6; c++) begin
      idle();
      cwo_ready = 1; ccwo_ready = 1; pero = 1;
      eval_cycle();
      check1("no_stale", cwo_valid | ccwo_valid | peso, 1'b0);
      advance();
    end

    // Randomized traffic: 10000 alternating-VC injections plus 4000 ejections.
    sent_inj = 0; got_inj = 0; sent_ej = 0; got_ej = 0;
    for (int k = 0; k < 10000; k++) begin
      d = 1'($urandom_range(1));
      h = 8'($urandom_range(255, 1));
      vc = k[0];
      p = mk(vc, d, h, 16'($urandom), 32'(k));
      nic_q[vc].push_back(p);
      p[55:48] = h - 8'd1;
      idx = int'(vc) * 2 + int'(d);
      inj_exp[idx].push_back(p);
      sent_inj++;
    end
    for (int k = 0; k < 4000; k++) begin
      d  = 1'($urandom_range(1));
      vc = 1'($urandom_range(1));
      p = mk(vc, d, 8'd0, {d, 15'(k)}, 32'h8000_0000 | 32'(k));
      src_q[d].push_back(p);
      idx = int'(vc) * 2 + int'(d);
      ej_exp[idx].push_back(p);
      sent_ej++;
    end

    done = 0;
    for (int cyc = 0; cyc < 60000 && !done; cyc++) begin
      pesi = (nic_q[m_pol].size() != 0) && ($urandom_range(3) != 0);
      pedi = pesi ? nic_q[m_pol][0] : {$urandom, $urandom};
      cwo_ready  = ($urandom_range(3) != 0);
      ccwo_ready = ($urandom_range(3) != 0);
      pero       = ($urandom_range(3) != 0);
      cwi_valid  = (src_q[0].size() != 0) && ($urandom_range(3) != 0);
      cwi_data   = cwi_valid ? src_q[0][0] : '0;
      ccwi_valid = (src_q[1].size() != 0) && ($urandom_range(3) != 0);
      ccwi_data  = ccwi_valid ? src_q[1][0] : '0;
      eval_cycle();

      if (cwo_valid === 1'b1 && cwo_ready) begin
        idx = int'(cwo_data[63]) * 2;
        if (inj_exp[idx].size() == 0) check1("sb_cw_extra", 1'b1, 1'b0);
        else begin
          tmp = inj_exp[idx].pop_front();
          check("sb_cw_order", cwo_data, tmp);
          got_inj++;
        end
      end
      if (ccwo_valid === 1'b1 && ccwo_ready) begin
        idx = int'(ccwo_data[63]) * 2 + 1;
        if (inj_exp[idx].size() == 0) check1("sb_ccw_extra", 1'b1, 1'b0);
        else begin
          tmp = inj_exp[idx].pop_front();
          check("sb_ccw_order", ccwo_data, tmp);
          got_inj++;
        end
      end
      if (peso === 1'b1) begin
        idx = int'(pedo[63]) * 2 + int'(pedo[47]);
        if (ej_exp[idx].size() == 0) check1("sb_nic_extra", 1'b1, 1'b0);
        else begin
          tmp = ej_exp[idx].pop_front();
          check("sb_nic_order", pedo, tmp);
          got_ej++;
        end
      end

      if (pesi && x_peri) tmp = nic_q[m_pol].pop_front();
      if (x_cwi_r)  tmp = src_q[0].pop_front();
      if (x_ccwi_r) tmp = src_q[1].pop_front();
      advance();
      done = all_empty();
    end
    check1("random_done", done, 1'b1);
    check("inj_count", 64'(got_inj), 64'(sent_inj));
    check("ej_count", 64'(got_ej), 64'(sent_ej));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cardinal_pe_port.md
# cardinal_pe_port

Processor-element port of a Cardinal ring router. It sits directly between `cardinal_nic` and the router's clockwise (cw) and counter-clockwise (ccw) ring pipelines. It accepts packets from the NIC output channel and hands them to the ring direction selected by the header. It also collects packets whose hop count has expired from both ring directions and delivers them to the NIC input channel. Each virtual channel (VC) has one-entry buffers, scheduled by the even/odd polarity scheme.

## Interface
- PACKET_SIZE, 64, packet width. Fields use MSB-first bit numbering [0:63] and are fixed:
  - bit 0: VC.
  - bit 1: direction (0 = cw, 1 = ccw).
  - bits 8:15: hop count.
  - bits 16:31: source.
  - bits 32:63: payload.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- polarity  out  1  0 after reset, toggles every cycle. Drives the NIC `net_polarity`.
- pesi  in  1  NIC→port send (NIC `net_so`).
- peri  out  1  port ready to accept from the NIC (NIC `net_ro`).
- pedi  in  PACKET_SIZE  NIC→port data.
- peso  out  1  port→NIC send (NIC `net_si`).
- pero  in  1  NIC ready (NIC `net_ri`).
- pedo  out  PACKET_SIZE  port→NIC data.
- cwo_valid / ccwo_valid  out  1  injected packet offered to the cw / ccw ring.
- cwo_ready / ccwo_ready  in  1  ring accepts.
- cwo_data / ccwo_data  out  PACKET_SIZE  injected packet, hop field already decremented.
- cwi_valid / ccwi_valid  in  1  ring packet with hop = 0, destined here.
- cwi_ready / ccwi_ready  out  1  port accepts the ejected packet.
- cwi_data / ccwi_data  in  PACKET_SIZE  ejected packet.
- inj_err  out  1  sticky. Set when an injected packet arrives with hop = 0.

## Operation
- State:
  - inj_buf[v] and inj_full[v], for v ∈ {0,1}.
  - ej_buf[v] and ej_full[v].
  - rr[v]: ejection round-robin pointer (0 = cw preferred).
  - polarity register.
  - inj_err.
- Phase rule: in a cycle with polarity = p:
  - VC p is in its **external phase**: transfers with the NIC only.
  - VC ~p is in its **internal phase**: transfers with the ring only.
  - A buffer is therefore never written and read in the same cycle.
- Injection from the NIC:
  - peri = ~inj_full[p].
  - A transfer happens on pesi & peri.
  - The NIC only sends packets whose bit 0 equals p. If pedi[0] ≠ p, the packet is still stored in inj_buf[p]; VC is taken from the phase, not the header.
  - If hop = 0, the packet is dropped (not stored) and inj_err is set.
- Injection to the ring:
  - For v = ~p with inj_full[v], the packet is offered on cwo if bit 1 = 0, otherwise on ccwo.
  - Offered data carries hop − 1.
  - On ready, inj_full[v] clears.
  - At most one ring output is valid per cycle.
- Ejection from the ring:
  - For v = ~p, only inputs with data[0] = v are eligible.
  - If ej_full[v] = 0 and both inputs are eligible, grant cw when rr[v] = 0, else ccw. rr[v] toggles after each grant.
  - A single eligible input is granted directly and rr is unchanged.
  - The *_ready of the granted input is 1; all other ready outputs are 0.
- Ejection to the NIC:
  - peso = ej_full[p] & pero.
  - pedo = ej_buf[p].
  - ej_full[p] clears on peso.
  - pedo is 0 when ej_full[p] = 0.

## Timing
- Reset values:
  - All full flags 0; rr = 0; polarity 0; inj_err 0.
  - peri = 1.
  - peso 0; pedo 0.
  - All valid and ready outputs 0; data outputs 0.
- Reset is asynchronous. Asserting it mid-transfer discards every buffered packet immediately.
- Latency:
  - NIC→ring: offered 1 cycle after acceptance (next phase), earliest.
  - ring→NIC: peso 1 cycle after acceptance, earliest.
  - Throughput per VC: 1 packet per 2 cycles.
- Backpressure:
  - If cwo_ready = 0, the packet waits a further 2 cycles per retry, since it is only offered in internal phases.
  - While inj_full[v] = 1, peri is 0 in the external phases of VC v.
- Hop arithmetic: 8-bit. A hop of 1 on injection leaves as 0, which is legal (one-hop destination).
- inj_err clears only on reset.

## Test plan
- Reset, then NIC sends VC0, dir cw, hop 3, payload 0x11 at p = 0 → cwo_valid next cycle with hop 2 and payload 0x11; peri low only until drain.
- cwi and ccwi both present VC1 packets (payloads 0xA, 0xB) while ej_buf[1] is empty, pero = 1 → 0xA is delivered first on peso, then 0xB two cycles later; rr[1] ends at 0.
- Hold cwo_ready = 0 for 6 cycles with a cw packet buffered → offered only in internal phases, never dropped; peri stays 0 in the VC's external phases; the packet is delivered once ready rises.
- Inject a hop = 0 packet → not forwarded; inj_err = 1 and stays 1 until reset.
- Assert reset with all four buffers full → all valid outputs and peso are 0 immediately; after release peri = 1 and no stale packet emerges.
- 10000 alternating-VC packets, each with random direction → every payload appears exactly once, in per-VC and per-direction order.
